// File: rtl/cmd_resp_rx_pkg.sv
// Shared definitions for the SD CMD-line 48-bit response receiver:
// FSM states, frame bit positions and the CRC7 generator polynomial.
package cmd_resp_rx_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_START = 3'd1,
      SHIFT      = 3'd2,
      CHECK      = 3'd3,
      BUSY       = 3'd4,
      DONE       = 3'd5
   } rx_state_t;

   localparam int unsigned RESP_BITS = 48;
   localparam int unsigned IDX_LAST  = 7;
   localparam int unsigned CRC_FIRST = 40;
   localparam int unsigned END_BIT   = 47;
   localparam int unsigned BIT_W     = $clog2(RESP_BITS);

   // x^7 + x^3 + 1
   localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/cmd_resp_rx_crc7_ser.sv
// Serial CRC7, MSB first. clr zeroes the register; clr together with en
// restarts the CRC with bit_in as its first bit.
module crc7_ser
   import cmd_resp_rx_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic [6:0] base;
   logic [6:0] crc_d;
   logic       fb;

   always_comb begin
      base  = clr ? 7'h00 : crc;
      fb    = bit_in ^ base[6];
      crc_d = {base[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   crc <= 7'h00;
      else if (en)  crc <= crc_d;
      else if (clr) crc <= 7'h00;
   end

endmodule

// File: rtl/cmd_resp_rx.sv
// SD CMD-line receiver for 48-bit responses (R1/R1b/R6/R7): waits for the
// start bit, captures index/argument/CRC7, checks the frame, tracks R1b busy.
module cmd_resp_rx
   import cmd_resp_rx_pkg::*;
#(
   parameter int unsigned NCR_MAX  = 64,
   parameter int unsigned BUSY_MAX = 65535,
   parameter int unsigned BUSY_W   = 16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_in,
   input  logic        dat0_in,
   input  logic        arm,
   input  logic        busy_chk,
   input  logic [7:0]  cmdn,
   output logic        rx_busy,
   output logic        done,
   output logic [5:0]  resp_index,
   output logic [31:0] resp_arg,
   output logic        crc_err,
   output logic        idx_err,
   output logic        frame_err,
   output logic        timeout
);

   localparam int unsigned NCR_W = $clog2(NCR_MAX + 1);

   rx_state_t         state_q, state_d;
   logic [5:0]        cmd_idx_q, cmd_idx_d;
   logic              busy_chk_q, busy_chk_d;
   logic [NCR_W-1:0]  ncr_q, ncr_d;
   logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [6:0]        rx_crc_q, rx_crc_d;
   logic              rx_busy_d, done_d;
   logic [5:0]        resp_index_d;
   logic [31:0]       resp_arg_d;
   logic              crc_err_d, idx_err_d, frame_err_d, timeout_d;
   logic              crc_clr, crc_en;
   logic [6:0]        crc_calc;

   // Only the 6-bit index is compared; the 0x40 marker bits carry no information.
   logic unused_cmdn_hi;
   assign unused_cmdn_hi = ^cmdn[7:6];

   crc7_ser u_crc7 (
      .clk    (clk),
      .reset  (reset),
      .clr    (crc_clr),
      .en     (crc_en),
      .bit_in (cmd_in),
      .crc    (crc_calc)
   );

   always_comb begin
      state_d      = state_q;
      cmd_idx_d    = cmd_idx_q;
      busy_chk_d   = busy_chk_q;
      ncr_d        = ncr_q;
      busy_cnt_d   = busy_cnt_q;
      bit_d        = bit_q;
      rx_crc_d     = rx_crc_q;
      resp_index_d = resp_index;
      resp_arg_d   = resp_arg;
      crc_err_d    = crc_err;
      idx_err_d    = idx_err;
      frame_err_d  = frame_err;
      timeout_d    = timeout;
      crc_clr      = 1'b0;
      crc_en       = 1'b0;

      case (state_q)
         IDLE: begin
            if (arm) begin
               cmd_idx_d    = cmdn[5:0];
               busy_chk_d   = busy_chk;
               crc_err_d    = 1'b0;
               idx_err_d    = 1'b0;
               frame_err_d  = 1'b0;
               timeout_d    = 1'b0;
               resp_index_d = 6'h00;
               resp_arg_d   = 32'h0;
               ncr_d        = '0;
               state_d      = WAIT_START;
            end
         end
         WAIT_START: begin
            if (!cmd_in) begin
               crc_clr = 1'b1;
               crc_en  = 1'b1;
               bit_d   = BIT_W'(1);
               state_d = SHIFT;
            end else begin
               ncr_d = ncr_q + NCR_W'(1);
               if (ncr_d == NCR_W'(NCR_MAX)) begin
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         SHIFT: begin
            bit_d  = bit_q + BIT_W'(1);
            crc_en = (bit_q < BIT_W'(CRC_FIRST));
            if (bit_q == BIT_W'(1)) begin
               if (cmd_in) frame_err_d = 1'b1;
            end else if (bit_q <= BIT_W'(IDX_LAST)) begin
               resp_index_d = {resp_index[4:0], cmd_in};
            end else if (bit_q < BIT_W'(CRC_FIRST)) begin
               resp_arg_d = {resp_arg[30:0], cmd_in};
            end else if (bit_q < BIT_W'(END_BIT)) begin
               rx_crc_d = {rx_crc_q[5:0], cmd_in};
            end else begin
               if (!cmd_in) frame_err_d = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            crc_err_d  = (crc_calc != rx_crc_q);
            idx_err_d  = (resp_index != cmd_idx_q);
            busy_cnt_d = '0;
            state_d    = busy_chk_q ? BUSY : DONE;
         end
         BUSY: begin
            if (dat0_in) begin
               state_d = DONE;
            end else begin
               busy_cnt_d = busy_cnt_q + BUSY_W'(1);
               if (busy_cnt_d == BUSY_W'(BUSY_MAX)) begin
                  timeout_d = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      done_d    = (state_d == DONE);
      rx_busy_d = (state_d != IDLE) && (state_d != DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cmd_idx_q  <= 6'h00;
         busy_chk_q <= 1'b0;
         ncr_q      <= '0;
         busy_cnt_q <= '0;
         bit_q      <= '0;
         rx_crc_q   <= 7'h00;
         rx_busy    <= 1'b0;
         done       <= 1'b0;
         resp_index <= 6'h00;
         resp_arg   <= 32'h0;
         crc_err    <= 1'b0;
         idx_err    <= 1'b0;
         frame_err  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_idx_q  <= cmd_idx_d;
         busy_chk_q <= busy_chk_d;
         ncr_q      <= ncr_d;
         busy_cnt_q <= busy_cnt_d;
         bit_q      <= bit_d;
         rx_crc_q   <= rx_crc_d;
         rx_busy    <= rx_busy_d;
         done       <= done_d;
         resp_index <= resp_index_d;
         resp_arg   <= resp_arg_d;
         crc_err    <= crc_err_d;
         idx_err    <= idx_err_d;
         frame_err  <= frame_err_d;
         timeout    <= timeout_d;
      end
   end

endmodule

// File: tb/tb_cmd_resp_rx.sv
// Bench for cmd_resp_rx: directed and random responses checked against a
// frame-level model (CRC by polynomial division, latency by formula).
module tb_cmd_resp_rx;

   localparam int NCR_MAX  = 64;
   localparam int BUSY_MAX = 600;

   logic        clk = 1'b0;
   logic        reset, cmd_in, dat0_in, arm, busy_chk;
   logic [7:0]  cmdn;
   logic        rx_busy, done, crc_err, idx_err, frame_err, timeout;
   logic [5:0]  resp_index;
   logic [31:0] resp_arg;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cmd_resp_rx #(.NCR_MAX(NCR_MAX), .BUSY_MAX(BUSY_MAX), .BUSY_W(16)) dut (
      .clk(clk), .reset(reset), .cmd_in(cmd_in), .dat0_in(dat0_in), .arm(arm),
      .busy_chk(busy_chk), .cmdn(cmdn), .rx_busy(rx_busy), .done(done),
      .resp_index(resp_index), .resp_arg(resp_arg), .crc_err(crc_err),
      .idx_err(idx_err), .frame_err(frame_err), .timeout(timeout)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Remainder of m(x)*x^7 divided by x^7+x^3+1.
   function automatic logic [6:0] crc7_ref(input logic [39:0] m);
      logic [46:0] r;
      r = {m, 7'd0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] mk_frame(input logic tbit, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic ebit);
      logic [39:0] m;
      m = {1'b0, tbit, idx, arg};
      return {m, crc7_ref(m), ebit};
   endfunction

   // CMD level sampled at edge e after arm (edge 0); frame starts after wt idle samples.
   function automatic logic cmd_bit(input int e, input int wt, input logic [47:0] fr);
      if (e >= wt + 1 && e <= wt + 48) return fr[6'(47 - (e - wt - 1))];
      return 1'b1;
   endfunction

   // busy_low < 0 means DAT0 stays low forever.
   task automatic txn(input string tag, input int wt, input logic [47:0] fr, input logic has_frame,
                      input logic bchk, input logic [7:0] cn, input int busy_low, input logic rearm);
      logic rx_ok;
      int   exp_lat, lat, limit;
      rx_ok   = has_frame && (wt < NCR_MAX);
      exp_lat = !rx_ok ? NCR_MAX + 1
              : wt + 50 + (bchk ? ((busy_low < 0) ? BUSY_MAX : busy_low + 1) : 0);
      limit   = wt + 80 + BUSY_MAX;
      lat     = 0;
      for (int e = 0; e < limit && lat == 0; e++) begin
         @(negedge clk);
         arm      = (e == 0) || (rearm && e == wt + 20);
         cmdn     = (rearm && e == wt + 20) ? (cn ^ 8'h0F) : cn;
         busy_chk = (e == 0) ? bchk : ~bchk;
         cmd_in   = has_frame ? cmd_bit(e, wt, fr) : 1'b1;
         dat0_in  = bchk && ((busy_low < 0) || (e <= wt + 49 + busy_low)) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
         if (e == 0) check({tag, ".busy_on"}, 64'(rx_busy), 64'd1);
         if (done) lat = e + 1;
      end
      check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ".busy_off"}, 64'(rx_busy), 64'd0);
      check({tag, ".index"}, 64'(resp_index), rx_ok ? 64'(fr[45:40]) : 64'd0);
      check({tag, ".arg"}, 64'(resp_arg), rx_ok ? 64'(fr[39:8]) : 64'd0);
      check({tag, ".crc_err"}, 64'(crc_err), 64'(rx_ok && (fr[7:1] != crc7_ref(fr[47:8]))));
      check({tag, ".idx_err"}, 64'(idx_err), 64'(rx_ok && (fr[45:40] != cn[5:0])));
      check({tag, ".frame_err"}, 64'(frame_err), 64'(rx_ok && (fr[46] || !fr[0])));
      check({tag, ".timeout"}, 64'(timeout), 64'(!rx_ok || (bchk && busy_low < 0)));
      @(negedge clk);
      arm = 1'b0; cmd_in = 1'b1; dat0_in = 1'b1;
      @(posedge clk); #1;
      check({tag, ".done_drop"}, 64'(done), 64'd0);
      check({tag, ".arg_hold"}, 64'(resp_arg), rx_ok ? 64'(fr[39:8]) : 64'd0);
   endtask

   initial begin
      logic [47:0] f17, f12, fr;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [7:0]  cn;
      logic        tb_bit, eb, bc, seen_done;
      int          wt, bl;

      reset = 1'b0; arm = 1'b0; busy_chk = 1'b0; cmdn = 8'h00; cmd_in = 1'b1; dat0_in = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.rx_busy", 64'(rx_busy), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check("rst.index", 64'(resp_index), 64'd0);
      check("rst.arg", 64'(resp_arg), 64'd0);
      check("rst.flags", 64'({crc_err, idx_err, frame_err, timeout}), 64'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      f17 = mk_frame(1'b0, 6'h11, 32'h0000_0900, 1'b1);
      f12 = mk_frame(1'b0, 6'h0C, 32'h0000_0B00, 1'b1);
      txn("r1_cmd17",  5, f17, 1'b1, 1'b0, 8'h51, 0, 1'b0);
      txn("crc_flip",  5, f17 ^ (48'h1 << 20), 1'b1, 1'b0, 8'h51, 0, 1'b0);
      txn("idx_bad",   5, f17, 1'b1, 1'b0, 8'h58, 0, 1'b0);
      txn("ncr_to",    0, f17, 1'b0, 1'b0, 8'h51, 0, 1'b0);
      txn("r1b_100",   3, f12, 1'b1, 1'b1, 8'h4C, 100, 1'b0);
      txn("r1b_stuck", 3, f12, 1'b1, 1'b1, 8'h4C, -1, 1'b0);
      txn("r1b_high",  0, f12, 1'b1, 1'b1, 8'h4C, 0, 1'b0);
      txn("framing",   4, mk_frame(1'b1, 6'h11, 32'h0000_0900, 1'b0), 1'b1, 1'b0, 8'h51, 0, 1'b0);
      txn("ncr_last",  NCR_MAX - 1, f17, 1'b1, 1'b0, 8'h51, 0, 1'b0);
      txn("ncr_over",  NCR_MAX, f17, 1'b1, 1'b0, 8'h51, 0, 1'b0);
      txn("rearm_ign", 7, f17, 1'b1, 1'b0, 8'h51, 0, 1'b1);

      // Reset in the middle of a frame: bit 20 sampled, then reset.
      @(negedge clk);
      arm = 1'b1; busy_chk = 1'b0; cmdn = 8'h51; cmd_in = 1'b1;
      for (int e = 1; e <= 2 + 1 + 20; e++) begin
         @(negedge clk);
         arm = 1'b0; cmd_in = cmd_bit(e, 2, f17);
      end
      @(posedge clk); #2;
      check("midrst.busy_before", 64'(rx_busy), 64'd1);
      reset = 1'b0; #1;
      check("midrst.rx_busy", 64'(rx_busy), 64'd0);
      check("midrst.index", 64'(resp_index), 64'd0);
      check("midrst.arg", 64'(resp_arg), 64'd0);
      check("midrst.done", 64'(done), 64'd0);
      seen_done = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1; cmd_in = 1'b1;
      repeat (30) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      check("midrst.no_done", 64'(seen_done), 64'd0);
      txn("post_rst", 6, f12, 1'b1, 1'b0, 8'h4C, 0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         wt     = int'($urandom_range(0, 66));
         idx    = 6'($urandom);
         arg    = $urandom;
         cn     = ($urandom_range(0, 3) == 0) ? {2'b01, 6'($urandom)} : {2'b01, idx};
         tb_bit = ($urandom_range(0, 7) == 0);
         eb     = ($urandom_range(0, 7) != 0);
         fr     = mk_frame(tb_bit, idx, arg, eb);
         if ($urandom_range(0, 5) == 0) begin
            bl = int'($urandom_range(1, 46));
            fr[6'(bl)] = ~fr[6'(bl)];
         end
         bc = 1'($urandom_range(0, 1));
         bl = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 150));
         txn("rand", wt, fr, 1'b1, bc, cn, bl, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
